// File: rtl/store_rmw_if.sv
// Store request and data-memory bus between the MEM stage and the store RMW controller.
// slave = the controller side, master = pipeline plus memory side.
interface store_rmw_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_addr, mem_we, mem_wdata, busy, done, err
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_addr, mem_we, mem_wdata, busy, done, err
  );
endinterface

// File: rtl/store_rmw_controller.sv
// Turns SB/SH stores into read-merge-write on a word-wide synchronous memory;
// SW goes straight to a write. busy stalls the pipeline until the store finishes.
module store_rmw_controller #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  store_rmw_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, ERR} state_t;
  typedef enum logic [1:0] {OP_SB, OP_SH, OP_SW, OP_ILL} op_t;

  state_t state_q, state_d;

  op_t                   req_op;
  logic                  accept;
  logic                  bad_req;
  op_t                   op_q;
  logic [1:0]            lane_q;
  logic [15:0]           data_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic                  mem_we_q;
  logic [31:0]           merged;

  assign req_op  = op_t'(bus.req_op);
  assign accept  = (state_q == IDLE) && bus.req_valid;
  assign bad_req = (req_op == OP_ILL)
                || ((req_op == OP_SH) && bus.req_addr[0])
                || ((req_op == OP_SW) && (bus.req_addr[1:0] != 2'b00));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bad_req)               state_d = ERR;
          else if (req_op == OP_SW)  state_d = WRITE;
          else                       state_d = READ;
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = WRITE;
      WRITE:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Little-endian lane merge; only the addressed lanes of data_q replace read data.
  always_comb begin
    merged = bus.mem_rdata;
    if (op_q == OP_SB) begin
      unique case (lane_q)
        2'd0: merged[7:0]   = data_q[7:0];
        2'd1: merged[15:8]  = data_q[7:0];
        2'd2: merged[23:16] = data_q[7:0];
        2'd3: merged[31:24] = data_q[7:0];
        default: merged = bus.mem_rdata;
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = data_q;
    end else begin
      merged[15:0] = data_q;
    end
  end

  // NOTE: bus-facing datapath registers are reset so no stale address/data is driven after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      op_q        <= OP_SB;
      lane_q      <= 2'b00;
      data_q      <= '0;
    end else begin
      mem_we_q <= (state_d == WRITE);
      if (accept) begin
        op_q       <= req_op;
        lane_q     <= bus.req_addr[1:0];
        data_q     <= bus.req_wdata[15:0];
        mem_addr_q <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
        if (req_op == OP_SW) mem_wdata_q <= bus.req_wdata;
      end
      // Read data is only trusted in CAPTURE, one cycle after READ presented the address.
      if (state_q == CAPTURE) mem_wdata_q <= merged;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == WRITE);
  assign bus.err       = (state_q == ERR);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_rmw_controller.sv
// Scoreboard bench for store_rmw_controller: directed stores queue their expected
// memory write or error pulse; a negedge monitor pops and compares.
module tb_store_rmw_controller;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_rmw_if #(.ADDR_WIDTH(AW)) bus ();

  store_rmw_controller #(.ADDR_WIDTH(AW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Word memory with synchronous read and a preload port for test setup.
  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en)            mem[pl_idx] <= pl_data;
    else if (bus.mem_we)  mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[7:2]];
  end

  typedef struct {
    bit          is_err;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write or error pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1 || bus.err === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: mem_we=%0b err=%0b addr=0x%08h data=0x%08h, expected no response",
                 bus.mem_we, bus.err, bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_kind_err", 32'(bus.err), 32'(mon_e.is_err));
        if (mon_e.is_err) begin
          check("sb_err_no_we", 32'(bus.mem_we), 32'd0);
        end else begin
          check("sb_addr", bus.mem_addr, mon_e.addr);
          check("sb_data", bus.mem_wdata, mon_e.data);
          check("sb_done", 32'(bus.done), 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pl_idx  = addr[7:2];
    pl_data = data;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (bus.req_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (bus.req_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s_ready_timeout: req_ready=%0b after %0d cycles, expected 1", name, bus.req_ready, k);
    end
  endtask

  task automatic push_exp(input bit is_err, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.is_err = is_err;
    e.addr   = {addr[31:2], 2'b00};
    e.data   = data;
    sb_q.push_back(e);
  endtask

  // Issue one request; called #1 after a rising edge, returns #1 after ready is back.
  task automatic do_req(input string name, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit is_err,
                        input logic [31:0] exp_data, input int exp_lat);
    int n;
    push_exp(is_err, addr, exp_data);
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    wait_ready(name);
    tick();
    bus.req_valid = 1'b0;
    check({name, "_c1_busy"},  32'(bus.busy), 32'd1);
    check({name, "_c1_ready"}, 32'(bus.req_ready), 32'd0);
    n = 1;
    while (bus.req_ready !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  logic [31:0] sb_addr [4] = '{32'h22, 32'h20, 32'h21, 32'h23};
  logic [31:0] sb_exp  [4] = '{32'h11AB3344, 32'h112233AB, 32'h1122AB44, 32'hAB223344};
  logic [1:0]  er_op   [3] = '{2'd1, 2'd2, 2'd3};
  logic [31:0] er_addr [3] = '{32'h21, 32'h22, 32'h20};

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset values
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_mem_we",    32'(bus.mem_we), 32'd0);
    check("rst_done",      32'(bus.done), 32'd0);
    check("rst_err",       32'(bus.err), 32'd0);
    check("rst_busy",      32'(bus.busy), 32'd0);
    check("rst_mem_addr",  bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(bus.req_ready), 32'd1);

    // SW straight to write
    do_req("sw", 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 2);
    check("sw_mem", mem[4], 32'hDEADBEEF);

    // SB on every lane
    for (int i = 0; i < 4; i++) begin
      preload(32'h20, 32'h11223344);
      do_req("sb", 2'd0, sb_addr[i], 32'hFFFFFFAB, 1'b0, sb_exp[i], 4);
      check("sb_mem", mem[8], sb_exp[i]);
    end

    // SH upper and lower half; upper data bits must not leak
    preload(32'h20, 32'h11223344);
    do_req("sh_hi", 2'd1, 32'h22, 32'h5A5ACAFE, 1'b0, 32'hCAFE3344, 4);
    check("sh_hi_mem", mem[8], 32'hCAFE3344);
    preload(32'h20, 32'h11223344);
    do_req("sh_lo", 2'd1, 32'h20, 32'h5A5ACAFE, 1'b0, 32'h1122CAFE, 4);
    check("sh_lo_mem", mem[8], 32'h1122CAFE);

    // Misaligned / illegal requests
    preload(32'h20, 32'h11223344);
    for (int i = 0; i < 3; i++) begin
      do_req("err", er_op[i], er_addr[i], 32'h99999999, 1'b1, 32'h0, 2);
      check("err_mem", mem[8], 32'h11223344);
    end

    // Reset during CAPTURE: the write must never happen
    preload(32'h40, 32'hA5A5A5A5);
    bus.req_op    = 2'd0;
    bus.req_addr  = 32'h41;
    bus.req_wdata = 32'h0000003C;
    bus.req_valid = 1'b1;
    wait_ready("rstcap");
    tick();                 // cycle 1: READ
    bus.req_valid = 1'b0;
    tick();                 // cycle 2: CAPTURE
    rst_n = 1'b0;
    tick();
    check("rstcap_mem_we",    32'(bus.mem_we), 32'd0);
    check("rstcap_busy",      32'(bus.busy), 32'd0);
    check("rstcap_mem_wdata", bus.mem_wdata, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rstcap_ready", 32'(bus.req_ready), 32'd1);
    repeat (3) tick();
    check("rstcap_mem", mem[16], 32'hA5A5A5A5);

    // Back-to-back: second SB held through the busy window, accepted in the IDLE gap
    preload(32'h30, 32'h55667788);
    push_exp(1'b0, 32'h30, 32'h556677AB);
    push_exp(1'b0, 32'h30, 32'hCD6677AB);
    bus.req_op    = 2'd0;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h000000AB;
    bus.req_valid = 1'b1;
    wait_ready("b2b");
    tick();                 // cycle 1
    bus.req_addr  = 32'h33;
    bus.req_wdata = 32'h000000CD;
    for (int c = 1; c <= 3; c++) begin
      check("b2b_busy_window", 32'(bus.busy), 32'd1);
      tick();
    end
    check("b2b_gap_busy",  32'(bus.busy), 32'd0);
    check("b2b_gap_ready", 32'(bus.req_ready), 32'd1);
    tick();                 // cycle 5: second request in READ
    bus.req_valid = 1'b0;
    check("b2b_second_busy", 32'(bus.busy), 32'd1);
    wait_ready("b2b2");
    check("b2b_mem", mem[12], 32'hCD6677AB);

    repeat (3) tick();
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/store_rmw_controller.md
# store_rmw_controller

Sequencer for sub-word stores to the word-wide data memory in the MEM stage. Byte (SB) and halfword (SH) stores become a read-modify-write: read the containing word, merge the new byte lanes little-endian, write the word back. Word stores (SW) go straight to a write. The block asserts `busy` so the hazard unit stalls the pipeline until the store completes.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: byte-address width. Memory word address is `addr[ADDR_WIDTH-1:2]`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  the single clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  store request valid. Must be held with the other `req_*` inputs stable until accepted.
- `req_ready`  out  1  high only in IDLE. A request is accepted when `req_valid & req_ready` at a rising edge.
- `req_op`  in  2  store type: 0 = SB, 1 = SH, 2 = SW, 3 = illegal.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  32  store data from the register file. SB uses `[7:0]`, SH uses `[15:0]`.
- `mem_addr`  out  ADDR_WIDTH  word-aligned memory address (`[1:0]` always 0). Registered.
- `mem_we`  out  1  memory write enable. Registered; one-cycle pulse.
- `mem_wdata`  out  32  merged write word. Registered.
- `mem_rdata`  in  32  memory read data. Valid one cycle after `mem_addr` is presented with `mem_we=0` (synchronous read).
- `busy`  out  1  `state != IDLE`; used as the stall to the pipeline.
- `done`  out  1  one-cycle pulse in the cycle `mem_we` is high.
- `err`  out  1  one-cycle pulse for a misaligned or illegal request; no memory write occurs.

## Operation
- FSM states: IDLE, READ, CAPTURE, WRITE, ERR. State encoding is free.
- The following are latched on acceptance: `op_q`, `lane_q = req_addr[1:0]`, `data_q`, and the word address.

Transitions out of IDLE:
- If SH with `addr[0]=1`, SW with `addr[1:0]≠0`, or op 3 → ERR.
- Else if SW → WRITE, with `mem_wdata = req_wdata`.
- Else → READ.

Other states:
- READ: `mem_addr` is the word address and `mem_we=0`. Always → CAPTURE.
- CAPTURE: `mem_rdata` is valid this cycle. The merged word is registered into `mem_wdata`. Always → WRITE.
- WRITE: `mem_we=1` and `done=1`. Always → IDLE.
- ERR: `err=1`, `mem_we=0`. Always → IDLE.

Merge rules (R = `mem_rdata`, D = `data_q`):
- SB, lane 0: {R[31:8], D[7:0]}
- SB, lane 1: {R[31:16], D[7:0], R[7:0]}
- SB, lane 2: {R[31:24], D[7:0], R[15:0]}
- SB, lane 3: {D[7:0], R[23:0]}
- SH, lane 0: {R[31:16], D[15:0]}
- SH, lane 2: {D[15:0], R[15:0]}. The lower half is preserved from R[15:0], never R[31:16].

Additional rules:
- Unused bits of `req_wdata` never reach memory.
- `mem_addr` is held from READ through WRITE, so the read and write target the same word.

## Timing
Reset values (at the first edge with `rst_n=0`):
- state IDLE
- `mem_we=0`, `done=0`, `err=0`, `busy=0`
- `mem_addr=0`, `mem_wdata=0`
- `req_ready=1` after release.

Latency, with the accept edge as cycle 0:
- SW: WRITE in cycle 1, `req_ready` back in cycle 2. Throughput is one SW per 2 cycles.
- SB/SH: READ in cycle 1, CAPTURE in cycle 2, WRITE in cycle 3, `req_ready` back in cycle 4.
- Error: ERR in cycle 1, ready in cycle 2.

Boundary conditions:
- `req_valid` while busy: ignored, no side effect.
- Back-to-back requests: a request held across the WRITE→IDLE edge is accepted in the IDLE cycle.
- Reset in READ or CAPTURE: the write is never issued and no partial data reaches memory.
- Reset in WRITE: at the same edge `mem_we` drops to 0 in the following cycle. The write in progress during that cycle completes normally.
- `mem_rdata` is sampled only in CAPTURE. Changes in other cycles have no effect.

## Test plan
- Reset, then SW, addr 0x10, data 0xDEADBEEF → cycle 1: `mem_we=1`, `mem_addr=0x10`, `mem_wdata=0xDEADBEEF`, `done=1`; `req_ready=1` in cycle 2; no read cycle.
- Memory word 0x11223344 at 0x20. SB, addr 0x22, data 0xFFFFFFAB → write 0x11AB3344 in cycle 3. Repeat for lanes 0, 1, 3 → 0x112233AB, 0x1122AB44, 0xAB223344.
- Memory word 0x11223344. SH, addr 0x22, data 0x0000CAFE → 0xCAFE3344. SH, addr 0x20 → 0x1122CAFE.
- SH at addr 0x21, SW at addr 0x22, op 3 → each gives `err` pulse in cycle 1, `mem_we` never high, memory unchanged, ready in cycle 2.
- SB issued, `rst_n=0` asserted during CAPTURE → `mem_we` stays 0, memory unchanged, `busy=0` and `req_ready=1` after release.
- `req_valid` held high with a second SB during the busy window → second request accepted exactly in the IDLE cycle after the first WRITE; `busy` gap of one cycle.
